// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: walks two operand memories and drives a pipelined
// 9x9 multiply-accumulate block to produce one signed dot product per job.
// The MAC control outputs are decoded from the state register, so an
// asynchronous clear drops them to zero immediately.
module mac_dot_sequencer #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 9,
   parameter int RES_W   = 19,
   parameter int MAC_LAT = 2
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_len,
   input  logic [ADDR_W-1:0] i_base_a,
   input  logic [ADDR_W-1:0] i_base_b,
   output logic              o_busy,
   output logic              o_done,
   output logic [RES_W-1:0]  o_result,
   output logic [ADDR_W-1:0] o_mem_a_addr,
   output logic [ADDR_W-1:0] o_mem_b_addr,
   input  logic [DATA_W-1:0] i_mem_a_q,
   input  logic [DATA_W-1:0] i_mem_b_q,
   output logic [DATA_W-1:0] o_mac_dataa,
   output logic [DATA_W-1:0] o_mac_datab,
   output logic              o_mac_clken,
   output logic              o_mac_sload,
   input  logic [RES_W-1:0]  i_mac_result
);

   // Flush counter only needs to reach MAC_LAT-2.
   localparam int FL_W = $clog2(MAC_LAT) + 1;
   localparam logic [ADDR_W-1:0] A_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [FL_W-1:0]   F_ONE = {{(FL_W-1){1'b0}}, 1'b1};
   localparam logic [FL_W-1:0]   F_END = FL_W'(MAC_LAT - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_RUN,
      S_FLUSH,
      S_CAPTURE
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [ADDR_W-1:0]  r_len;
   logic [ADDR_W-1:0]  r_cnt;
   logic [ADDR_W-1:0]  r_addr_a;
   logic [ADDR_W-1:0]  r_addr_b;
   logic [FL_W-1:0]    r_fcnt;
   logic               r_zero;
   logic               r_done;
   logic [RES_W-1:0]   r_result;
   logic               w_run_last;
   logic               w_flush_last;

   assign w_run_last   = (r_cnt == (r_len - A_ONE));
   assign w_flush_last = (r_fcnt == F_END);

   // State register; aclr aborts any job in flight.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   // Next-state decode and MAC control strobes.
   always_comb begin
      w_next      = r_state;
      o_busy      = 1'b1;
      o_mac_clken = 1'b0;
      o_mac_sload = 1'b0;
      o_mac_dataa = '0;
      o_mac_datab = '0;
      case (r_state)
         S_IDLE: begin
            o_busy = 1'b0;
            if (i_start) w_next = (i_len == '0) ? S_CAPTURE : S_FETCH;
         end
         S_FETCH: begin
            w_next = S_RUN;
         end
         S_RUN: begin
            o_mac_clken = 1'b1;
            // First pair reloads the accumulator, discarding the prior job.
            o_mac_sload = (r_cnt == '0);
            o_mac_dataa = i_mem_a_q;
            o_mac_datab = i_mem_b_q;
            if (w_run_last) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            // Zero operands push the last real pair through the pipeline.
            o_mac_clken = 1'b1;
            if (w_flush_last) w_next = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // Job latch, address generation, element/flush counters and result capture.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         r_len    <= '0;
         r_cnt    <= '0;
         r_addr_a <= '0;
         r_addr_b <= '0;
         r_fcnt   <= '0;
         r_zero   <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_len    <= i_len;
                  r_addr_a <= i_base_a;
                  r_addr_b <= i_base_b;
                  r_zero   <= (i_len == '0);
               end
            end
            S_FETCH: begin
               // Base addresses were on the bus this cycle; data lands in RUN.
               r_cnt    <= '0;
               r_addr_a <= r_addr_a + A_ONE;
               r_addr_b <= r_addr_b + A_ONE;
            end
            S_RUN: begin
               r_cnt    <= r_cnt + A_ONE;
               r_addr_a <= r_addr_a + A_ONE;
               r_addr_b <= r_addr_b + A_ONE;
               r_fcnt   <= '0;
            end
            S_FLUSH: begin
               r_fcnt <= r_fcnt + F_ONE;
            end
            S_CAPTURE: begin
               r_result <= r_zero ? '0 : i_mac_result;
               r_done   <= 1'b1;
            end
            default: begin
               r_cnt <= '0;
            end
         endcase
      end
   end

   assign o_done       = r_done;
   assign o_result     = r_result;
   assign o_mem_a_addr = r_addr_a;
   assign o_mem_b_addr = r_addr_b;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer: behavioural memories and MAC, a queue of
// expected results filled on job acceptance and drained by a done monitor.
module tb_mac_dot_sequencer;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 9;
   localparam int RES_W   = 19;
   localparam int MAC_LAT = 2;

   logic              clk = 1'b0;
   logic              aclr;
   logic              i_start;
   logic [ADDR_W-1:0] i_len, i_base_a, i_base_b;
   logic              o_busy, o_done;
   logic [RES_W-1:0]  o_result;
   logic [ADDR_W-1:0] o_mem_a_addr, o_mem_b_addr;
   logic [DATA_W-1:0] i_mem_a_q, i_mem_b_q;
   logic [DATA_W-1:0] o_mac_dataa, o_mac_datab;
   logic              o_mac_clken, o_mac_sload;
   logic [RES_W-1:0]  i_mac_result;

   mac_dot_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RES_W(RES_W), .MAC_LAT(MAC_LAT)) dut (
      .clk(clk), .aclr(aclr), .i_start(i_start), .i_len(i_len),
      .i_base_a(i_base_a), .i_base_b(i_base_b), .o_busy(o_busy), .o_done(o_done),
      .o_result(o_result), .o_mem_a_addr(o_mem_a_addr), .o_mem_b_addr(o_mem_b_addr),
      .i_mem_a_q(i_mem_a_q), .i_mem_b_q(i_mem_b_q), .o_mac_dataa(o_mac_dataa),
      .o_mac_datab(o_mac_datab), .o_mac_clken(o_mac_clken), .o_mac_sload(o_mac_sload),
      .i_mac_result(i_mac_result)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Synchronous-read operand memories.
   logic [DATA_W-1:0] mem_a [256];
   logic [DATA_W-1:0] mem_b [256];
   always @(posedge clk) begin
      i_mem_a_q <= mem_a[o_mem_a_addr];
      i_mem_b_q <= mem_b[o_mem_b_addr];
   end

   // Two-stage MAC: registered product, then accumulate (or reload).
   logic [RES_W-1:0] mac_p;
   logic             mac_ld;
   logic [RES_W-1:0] mac_acc;
   always @(posedge clk or posedge aclr) begin
      if (aclr) begin
         mac_p <= '0; mac_ld <= 1'b0; mac_acc <= '0;
      end else if (o_mac_clken) begin
         mac_p   <= RES_W'(int'($signed(o_mac_dataa)) * int'($signed(o_mac_datab)));
         mac_ld  <= o_mac_sload;
         mac_acc <= mac_ld ? mac_p : mac_acc + mac_p;
      end
   end
   assign i_mac_result = mac_acc;

   // Reference dot product straight from memory contents, wrapped to RES_W.
   function automatic logic [RES_W-1:0] ref_dot(input int ba, input int bb, input int ln);
      longint s = 0;
      for (int i = 0; i < ln; i++) begin
         int av, bv;
         logic signed [DATA_W-1:0] ta, tb;
         ta = mem_a[(ba + i) % 256];
         tb = mem_b[(bb + i) % 256];
         av = ta;
         bv = tb;
         s += longint'(av) * longint'(bv);
      end
      return RES_W'(s);
   endfunction

   typedef struct {
      logic [RES_W-1:0] res;
      int               acc_cyc;
      int               len;
   } exp_t;
   exp_t exp_q[$];

   // Done monitor: pops the oldest expectation and checks result, latency and MAC strobe counts.
   int n_clken = 0;
   int n_sload = 0;
   always @(negedge clk) begin
      if (aclr) begin
         n_clken = 0;
         n_sload = 0;
      end else begin
         if (o_mac_clken) n_clken++;
         if (o_mac_sload) n_sload++;
         if (o_done) begin
            if (exp_q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("result", o_result, e.res);
               chk("done_latency", cyc - e.acc_cyc + 1,
                   (e.len == 0) ? 2 : e.len + MAC_LAT + 2);
               chk("clken_cycles", n_clken, (e.len == 0) ? 0 : e.len + MAC_LAT - 1);
               chk("sload_cycles", n_sload, (e.len == 0) ? 0 : 1);
            end
            n_clken = 0;
            n_sload = 0;
         end
      end
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, o_busy, 0);
      chk({tag, "_done"}, o_done, 0);
      chk({tag, "_result"}, o_result, 0);
      chk({tag, "_addr_a"}, o_mem_a_addr, 0);
      chk({tag, "_addr_b"}, o_mem_b_addr, 0);
      chk({tag, "_dataa"}, o_mac_dataa, 0);
      chk({tag, "_datab"}, o_mac_datab, 0);
      chk({tag, "_clken"}, o_mac_clken, 0);
      chk({tag, "_sload"}, o_mac_sload, 0);
   endtask

   // Issue one job at the current negedge; returns at the negedge of the done cycle.
   task automatic run_job(input int ba, input int bb, input int ln, input bit noise, input int abort_c);
      int dl;
      dl = (ln == 0) ? 2 : ln + MAC_LAT + 2;
      i_base_a = ADDR_W'(ba);
      i_base_b = ADDR_W'(bb);
      i_len    = ADDR_W'(ln);
      i_start  = 1'b1;
      for (int c = 1; c <= dl; c++) begin
         @(negedge clk);
         i_start = noise && (c == 1);
         if (i_start) begin
            i_len    = ADDR_W'($urandom_range(0, 255));
            i_base_a = ADDR_W'($urandom_range(0, 255));
            i_base_b = ADDR_W'($urandom_range(0, 255));
         end
         if (c == 1) begin
            exp_t e;
            e.res = ref_dot(ba, bb, ln);
            e.acc_cyc = cyc;
            e.len = ln;
            exp_q.push_back(e);
         end
         if (c == abort_c) begin
            #2 aclr = 1'b1;
            exp_q.delete();
            #1 chk_all_zero("abort");
            @(negedge clk);
            @(negedge clk);
            #2 aclr = 1'b0;
            @(negedge clk);
            return;
         end
         if (c <= ln) begin
            chk("addr_a", o_mem_a_addr, (ba + c - 1) % 256);
            chk("addr_b", o_mem_b_addr, (bb + c - 1) % 256);
         end
         chk("clken", o_mac_clken, (ln > 0 && c >= 2 && c <= ln + MAC_LAT) ? 1 : 0);
         chk("sload", o_mac_sload, (ln > 0 && c == 2) ? 1 : 0);
         chk("busy", o_busy, (c < dl) ? 1 : 0);
      end
   endtask

   initial begin
      aclr = 1'b1;
      i_start = 1'b0;
      i_len = '0;
      i_base_a = '0;
      i_base_b = '0;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = DATA_W'($urandom_range(0, 511));
         mem_b[i] = DATA_W'($urandom_range(0, 511));
      end
      // Directed operand sets.
      for (int i = 0; i < 4; i++) begin
         mem_a[i]      = DATA_W'(i + 1);
         mem_b[16 + i] = DATA_W'(i + 5);
         mem_a[48 + i] = 9'd255;
         mem_b[56 + i] = 9'd255;
      end
      mem_a[32] = 9'h100; mem_a[33] = 9'd255;
      mem_b[40] = 9'h100; mem_b[41] = 9'h100;
      mem_a[100] = 9'd2;  mem_b[101] = 9'd3;

      repeat (2) @(negedge clk);
      chk_all_zero("reset");
      #2 aclr = 1'b0;
      @(negedge clk);

      run_job(0, 16, 4, 0, 0);          // 1..4 . 5..8 = 70
      repeat (2) @(negedge clk);
      run_job(32, 40, 2, 0, 0);         // signed extremes = 256
      repeat (1) @(negedge clk);
      run_job(48, 56, 4, 0, 0);         // 4*255*255 = 260100
      repeat (3) @(negedge clk);
      run_job(10, 20, 0, 0, 0);         // len 0 with stale MAC state
      repeat (2) @(negedge clk);
      run_job(254, 250, 4, 0, 0);       // address wrap
      repeat (2) @(negedge clk);
      run_job(60, 70, 3, 0, 0);         // back-to-back pair
      run_job(100, 101, 1, 1, 0);       // = 6, with an ignored start while busy
      repeat (2) @(negedge clk);
      run_job(5, 9, 6, 0, 3);           // aclr in second RUN cycle
      run_job(0, 16, 4, 0, 0);          // recovers after abort

      for (int k = 0; k < 25; k++) begin
         int ln;
         ln = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
         run_job(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), ln,
                 1'($urandom_range(0, 1)), 0);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (4) @(negedge clk);
      chk("pending_expectations", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mac_dot_sequencer.md
# mac_dot_sequencer

Sequencer that computes signed dot products on the shared 9x9 multiply-accumulate datapath. It accepts a job (two base addresses plus an element count) and generates addresses into two synchronous operand memories. It drives the MAC operand, clock-enable and load strobes, flushes the MAC pipeline, then captures the 19-bit accumulated result with a one-cycle done pulse. It sits between the control/CPU-side job interface and the MAC instance, and is the only driver of the MAC's control inputs.

## Interface
- ADDR_W, 8, width of memory addresses and of the element count
- DATA_W, 9, operand width; two's complement
- RES_W, 19, accumulator/result width; two's complement
- MAC_LAT, 2, MAC cycles from an operand pair presented with clken=1 to its contribution being visible on mac_result (minimum 2)
- clk  in  1  clock, rising edge
- aclr  in  1  reset, asynchronous, active-high
- start  in  1  job request; sampled only in IDLE
- len  in  ADDR_W  element count, 0..2^ADDR_W-1
- base_a, base_b  in  ADDR_W  first address of vector A / vector B
- busy  out  1  job in progress
- done  out  1  one-cycle pulse; result valid from this cycle on
- result  out  RES_W  last captured dot product; held until next capture
- mem_a_addr, mem_b_addr  out  ADDR_W  operand memory read addresses
- mem_a_q, mem_b_q  in  DATA_W  read data; 1-cycle synchronous read latency
- mac_dataa, mac_datab  out  DATA_W  MAC operands
- mac_clken  out  1  MAC clock enable
- mac_sload  out  1  MAC accumulator clear-and-load for the current pair
- mac_result  in  RES_W  MAC accumulator output

## Operation
- States: IDLE, FETCH, RUN, FLUSH, CAPTURE.
- IDLE: busy=0, mac_clken=0. When start=1, latch len, base_a, base_b. If len=0, go to CAPTURE with a zero flag. Otherwise go to FETCH.
- FETCH (1 cycle): mem_*_addr = base_*; element counter cleared.
- RUN (len cycles): mac_dataa/b = mem_a_q/mem_b_q passed through combinationally, mac_clken=1. mac_sload=1 only in the first RUN cycle. Each cycle, addresses increment by 1 modulo 2^ADDR_W. After element len-1, go to FLUSH.
- FLUSH (MAC_LAT-1 cycles): mac_clken=1, mac_dataa/b=0, mac_sload=0.
- CAPTURE (1 cycle): mac_clken=0. At the closing edge, result <= mac_result, or 0 if the zero flag is set. done is registered to 1. Go to IDLE.
- Outside RUN/FLUSH, mac_dataa/b=0 and mac_sload=0. mac_clken=0 in IDLE, FETCH and CAPTURE, so the MAC holds its state.
- start while busy is ignored, not queued. Job inputs are sampled only on the accepting edge.
- Arithmetic: products and sum are the MAC's. Accumulator overflow wraps modulo 2^RES_W and is not flagged.
- Address wrap: base+len beyond 2^ADDR_W-1 wraps to 0 with no error.
- aclr (any state, including mid-RUN/FLUSH): immediately IDLE. busy, done, result, mem_*_addr, mac_dataa/b, mac_clken and mac_sload all = 0. The aborted job produces no done.

## Timing
- Reset values: all outputs 0.
- Cycle 0 = the cycle start is sampled high in IDLE.
- Cycle 1 = FETCH.
- Cycles 2..len+1 = RUN; element i is presented in cycle i+2.
- Cycles len+2..len+MAC_LAT = FLUSH.
- Cycle len+MAC_LAT+1 = CAPTURE.
- Cycle len+MAC_LAT+2: done=1, busy=0, result valid, state IDLE. A new start is accepted in this same cycle.
- len=0: busy=1 in cycle 1 (CAPTURE); done=1, result=0 in cycle 2. No MAC activity.
- busy=1 exactly from cycle 1 through CAPTURE.
- Back-to-back jobs are independent: mac_sload on the first element discards the prior sum.

## Test plan
- MAC_LAT=2, A={1,2,3,4}, B={5,6,7,8}, len=4 -> mac_sload high in cycle 2 only; mac_clken high cycles 2..6; done and result=70 in cycle 8.
- Signed extremes: A={-256,255}, B={-256,-256}, len=2 -> result=256. A={255}×4, B={255}×4 -> 260100.
- len=0 with stale MAC state -> done in cycle 2, result=0, mac_clken never asserted.
- Wrap: ADDR_W=8, base_a=254, len=4 -> mem_a_addr sequence 254,255,0,1; result matches the reference dot product.
- Back-to-back jobs: start re-asserted in the done cycle; second job (A={2},B={3}) -> result=6, first job's sum not included. start pulses while busy are ignored.
- aclr asserted in the second RUN cycle -> all outputs 0 immediately, no done. The next job completes with the correct result.
